// File: rtl/mmio_register_file_pkg.sv
// CAPI MMIO types, FSM state encoding and helpers shared by the MMIO slave.
// Provides parity, byte-swap and the full AFU-descriptor cfg-space decode.
package mmio_register_file_pkg;

    typedef struct packed {
        logic        valid;
        logic        cfg;
        logic        read;
        logic        doubleword;
        logic [0:23] address;
        logic        address_parity;
        logic [0:63] data;
        logic        data_parity;
    } MMIOInterfaceInput;

    typedef struct packed {
        logic        ack;
        logic [0:63] data;
        logic        data_parity;
    } MMIOInterfaceOutput;

    typedef struct packed {
        logic [0:15] num_ints_per_process;
        logic [0:15] num_of_processes;
        logic [0:15] num_of_afu_crs;
        logic [0:15] req_prog_model;
        logic [0:55] afu_cr_len;
        logic [0:63] afu_cr_offset;
        logic        per_process_psa;
        logic        psa_required;
        logic [0:55] psa_length;
        logic [0:63] psa_offset;
        logic [0:55] afu_eb_len;
        logic [0:63] afu_eb_offset;
    } AFUDescriptor;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } mmio_state_t;

    function automatic logic odd_parity64(logic [0:63] d);
        return ~^d;
    endfunction

    function automatic logic odd_parity24(logic [0:23] d);
        return ~^d;
    endfunction

    function automatic logic [63:0] swap_endianness(logic [63:0] d);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i*8 +: 8] = d[(7-i)*8 +: 8];
        end
        return r;
    endfunction

    // Decode is on the dword-aligned address; word selection happens later.
    function automatic logic [63:0] read_afu_descriptor(
        logic [23:0]  addr,
        AFUDescriptor d
    );
        logic [63:0] r;
        r = '0;
        case ({addr[23:1], 1'b0})
            24'h000000: r = {d.num_ints_per_process, d.num_of_processes,
                             d.num_of_afu_crs, d.req_prog_model};
            24'h000008: r = {8'h0, d.afu_cr_len};
            24'h00000A: r = d.afu_cr_offset;
            24'h00000C: r = {6'h0, d.per_process_psa, d.psa_required,
                             d.psa_length};
            24'h00000E: r = d.psa_offset;
            24'h000010: r = {8'h0, d.afu_eb_len};
            24'h000012: r = d.afu_eb_offset;
            default:    r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mmio_cfg_decode.sv
// Combinational AFU-descriptor cfg-space read decode.
// Ports: addr_i (word address), desc_i (descriptor), data_o (64-bit cfg data).
module mmio_cfg_decode
    import mmio_register_file_pkg::*;
(
    input  logic [23:0]  addr_i,
    input  AFUDescriptor desc_i,
    output logic [63:0]  data_o
);

    assign data_o = read_afu_descriptor(addr_i, desc_i);

endmodule

// File: rtl/mmio_register_file.sv
// PSL MMIO slave: cfg-space descriptor reads plus NUM_REGS 64-bit AFU registers
// with RO mask, word/dword access, optional byte swap and programmable ack
// latency. Ports: clock, reset (async, high), mmio_in/mmio_out (PSL MMIO),
// descriptor, status_in (RO sources), reg_out, reg_wr_strobe, parity_error,
// protocol_error. Define MMIO_PARITY_CHECK_EN to check request parity.
module mmio_register_file
    import mmio_register_file_pkg::*;
#(
    parameter int                  NUM_REGS    = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter int                  ACK_LATENCY = 2,
    parameter bit                  SWAP_ENDIAN = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  MMIOInterfaceInput        mmio_in,
    output MMIOInterfaceOutput       mmio_out,
    input  AFUDescriptor             descriptor,
    input  logic [NUM_REGS*64-1:0]   status_in,
    output logic [NUM_REGS*64-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      reg_wr_strobe,
    output logic                     parity_error,
    output logic                     protocol_error
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    mmio_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        cfg_q, rd_q, dw_q, misal_q, perr_q;
    logic [23:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] regs_q [NUM_REGS];

    logic        proto_q, proto_d;
    logic        perr_err_q, perr_err_d;

    logic        accept, busy_hit, in_perr;

    assign accept   = mmio_in.valid && (state_q == IDLE);
    assign busy_hit = mmio_in.valid && (state_q != IDLE);

`ifdef MMIO_PARITY_CHECK_EN
    // Data parity only matters for writes; reads carry no payload.
    assign in_perr = (odd_parity24(mmio_in.address) != mmio_in.address_parity)
                  || (!mmio_in.read
                      && (odd_parity64(mmio_in.data) != mmio_in.data_parity));
`else
    logic unused_par;
    assign unused_par = mmio_in.address_parity ^ mmio_in.data_parity;
    assign in_perr    = 1'b0;
`endif

    // FSM next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (mmio_in.valid) begin
                    cnt_d   = 4'(ACK_LATENCY - 1);
                    state_d = (ACK_LATENCY <= 1) ? ACK : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign proto_d = proto_q | busy_hit
                   | (accept && mmio_in.doubleword && mmio_in.address[23]);
    assign perr_err_d = perr_err_q | (accept && in_perr);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cfg_q      <= 1'b0;
            rd_q       <= 1'b0;
            dw_q       <= 1'b0;
            misal_q    <= 1'b0;
            perr_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            proto_q    <= 1'b0;
            perr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            proto_q    <= proto_d;
            perr_err_q <= perr_err_d;
            if (accept) begin
                cfg_q   <= mmio_in.cfg;
                rd_q    <= mmio_in.read;
                dw_q    <= mmio_in.doubleword;
                addr_q  <= mmio_in.address;
                wdata_q <= mmio_in.data;
                misal_q <= mmio_in.doubleword && mmio_in.address[23];
                perr_q  <= in_perr;
            end
        end
    end

    assign protocol_error = proto_q;
`ifdef MMIO_PARITY_CHECK_EN
    assign parity_error = perr_err_q;
`else
    assign parity_error = 1'b0;
`endif

    // Register selection (addr_q[0] is the word-select bit)
    logic [22:0]   idx;
    logic [IW-1:0] sel;
    logic          idx_ok, ro;

    assign idx    = addr_q[23:1];
    assign sel    = addr_q[IW:1];
    assign idx_ok = idx < 23'(NUM_REGS);
    assign ro     = RO_MASK[sel];

    logic [63:0] cfg_data;

    mmio_cfg_decode u_cfg (
        .addr_i (addr_q),
        .desc_i (descriptor),
        .data_o (cfg_data)
    );

    // Read path: "logical" is the host view, swapped from storage.
    logic [63:0] src, logical, raw, rdata;

    always_comb begin
        src     = ro ? status_in[{sel, 6'b0} +: 64] : regs_q[sel];
        logical = SWAP_ENDIAN ? swap_endianness(src) : src;
        raw     = '0;
        if (cfg_q) begin
            raw = cfg_data;
        end else if (idx_ok) begin
            raw = logical;
        end
        if (misal_q || perr_q) begin
            raw = '0;
        end
        if (dw_q) begin
            rdata = raw;
        end else if (addr_q[0]) begin
            rdata = {raw[31:0], raw[31:0]};
        end else begin
            rdata = {raw[63:32], raw[63:32]};
        end
    end

    // Write path: merge a word into the host view, then re-swap to store.
    logic [63:0] cur, merged, wstore;
    logic        we;

    always_comb begin
        cur = SWAP_ENDIAN ? swap_endianness(regs_q[sel]) : regs_q[sel];
        if (dw_q) begin
            merged = wdata_q;
        end else if (addr_q[0]) begin
            merged = {cur[63:32], wdata_q[31:0]};
        end else begin
            merged = {wdata_q[31:0], cur[31:0]};
        end
        wstore = SWAP_ENDIAN ? swap_endianness(merged) : merged;
    end

    assign we = (state_q == ACK) && !cfg_q && !rd_q && idx_ok
             && !ro && !misal_q && !perr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[sel] <= wstore;
        end
    end

    always_comb begin
        reg_wr_strobe = '0;
        if (we) begin
            reg_wr_strobe[sel] = 1'b1;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[i*64 +: 64] = regs_q[i];
        end
    end

    // Outputs are zero outside the ack cycle, parity included.
    always_comb begin
        mmio_out             = '0;
        mmio_out.ack         = (state_q == ACK);
        if (state_q == ACK) begin
            mmio_out.data        = rd_q ? rdata : 64'h0;
            mmio_out.data_parity = odd_parity64(rd_q ? rdata : 64'h0);
        end
    end

endmodule

// File: tb/tb_mmio_register_file.sv
// Directed self-checking bench for mmio_register_file.
// NUM_REGS=16, RO_MASK bit 3, ACK_LATENCY=2, SWAP_ENDIAN=1.
module tb_mmio_register_file;
    import mmio_register_file_pkg::*;

    logic               clock;
    logic               reset;
    MMIOInterfaceInput  mmio_in;
    MMIOInterfaceOutput mmio_out;
    AFUDescriptor       descriptor;
    logic [1023:0]      status_in;
    logic [1023:0]      reg_out;
    logic [15:0]        reg_wr_strobe;
    logic               parity_error;
    logic               protocol_error;

    int total = 0;
    int bad   = 0;

    mmio_register_file #(
        .NUM_REGS    (16),
        .RO_MASK     (16'h0008),
        .ACK_LATENCY (2),
        .SWAP_ENDIAN (1'b1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .mmio_in        (mmio_in),
        .mmio_out       (mmio_out),
        .descriptor     (descriptor),
        .status_in      (status_in),
        .reg_out        (reg_out),
        .reg_wr_strobe  (reg_wr_strobe),
        .parity_error   (parity_error),
        .protocol_error (protocol_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic xact(input logic cfg, input logic rd, input logic dw,
                        input logic [23:0] addr, input logic [63:0] data,
                        input logic flip,
                        output logic [63:0] rdata, output logic rpar,
                        output logic [15:0] stb, output int lat);
        @(negedge clock);
        mmio_in.valid          = 1'b1;
        mmio_in.cfg            = cfg;
        mmio_in.read           = rd;
        mmio_in.doubleword     = dw;
        mmio_in.address        = addr;
        mmio_in.address_parity = ~^addr;
        mmio_in.data           = data;
        mmio_in.data_parity    = (~^data) ^ flip;
        @(negedge clock);
        mmio_in.valid = 1'b0;
        lat   = 1;
        rdata = '0;
        rpar  = 1'b0;
        stb   = '0;
        while (!mmio_out.ack && lat < 16) begin
            @(negedge clock);
            lat++;
        end
        if (mmio_out.ack) begin
            rdata = mmio_out.data;
            rpar  = mmio_out.data_parity;
            stb   = reg_wr_strobe;
        end else begin
            lat = 99;
        end
    endtask

    logic [63:0] rd;
    logic        rp;
    logic [15:0] sb;
    int          lat;
    int          acks;

    initial begin
        reset      = 1'b1;
        mmio_in    = '0;
        descriptor = '0;
        status_in  = '0;
        descriptor.num_ints_per_process = 16'h0001;
        descriptor.num_of_processes     = 16'h0001;
        descriptor.num_of_afu_crs       = 16'h0001;
        descriptor.req_prog_model       = 16'h8010;
        descriptor.afu_cr_len           = 56'h100;
        descriptor.afu_cr_offset        = 64'h0123456789ABCDEF;
        status_in[3*64 +: 64]           = 64'hCAFE;

        repeat (2) @(negedge clock);
        check("rst_ack", 64'(mmio_out.ack), 64'h0);
        check("rst_data", mmio_out.data, 64'h0);
        check("rst_par", 64'(mmio_out.data_parity), 64'h0);
        check("rst_stb", 64'(reg_wr_strobe), 64'h0);
        check("rst_reg2", reg_out[2*64 +: 64], 64'h0);
        check("rst_perr", 64'(parity_error), 64'h0);
        check("rst_proto", 64'(protocol_error), 64'h0);
        reset = 1'b0;

        // dword write reg 2
        xact(1'b0, 1'b0, 1'b1, 24'h04, 64'h0011223344556677, 1'b0,
             rd, rp, sb, lat);
        check("wr_lat", 64'(lat), 64'd2);
        check("wr_stb", 64'(sb), 64'h0004);
        @(negedge clock);
        check("wr_stb_once", 64'(reg_wr_strobe), 64'h0);
        check("wr_reg2", reg_out[2*64 +: 64], 64'h7766554433221100);

        // dword read back
        xact(1'b0, 1'b1, 1'b1, 24'h04, 64'h0, 1'b0, rd, rp, sb, lat);
        check("rd_lat", 64'(lat), 64'd2);
        check("rd_data", rd, 64'h0011223344556677);
        check("rd_par", 64'(rp), 64'h1);
        check("rd_stb", 64'(sb), 64'h0);

        // word write low half, then word reads
        xact(1'b0, 1'b0, 1'b0, 24'h05, 64'hDEADBEEF, 1'b0, rd, rp, sb, lat);
        check("ww_stb", 64'(sb), 64'h0004);
        @(negedge clock);
        check("ww_reg2", reg_out[2*64 +: 64], 64'hEFBEADDE33221100);
        xact(1'b0, 1'b1, 1'b0, 24'h05, 64'h0, 1'b0, rd, rp, sb, lat);
        check("wr_lo", rd, 64'hDEADBEEFDEADBEEF);
        check("wr_lo_par", 64'(rp), 64'h1);
        xact(1'b0, 1'b1, 1'b0, 24'h04, 64'h0, 1'b0, rd, rp, sb, lat);
        check("wr_hi", rd, 64'h0011223300112233);

        // cfg reads
        xact(1'b1, 1'b1, 1'b1, 24'h00, 64'h0, 1'b0, rd, rp, sb, lat);
        check("cfg00", rd, 64'h0001000100018010);
        xact(1'b1, 1'b1, 1'b1, 24'h08, 64'h0, 1'b0, rd, rp, sb, lat);
        check("cfg08", rd, 64'h0000000000000100);
        xact(1'b1, 1'b1, 1'b1, 24'h0A, 64'h0, 1'b0, rd, rp, sb, lat);
        check("cfg0A", rd, 64'h0123456789ABCDEF);
        xact(1'b1, 1'b1, 1'b1, 24'h14, 64'h0, 1'b0, rd, rp, sb, lat);
        check("cfg14", rd, 64'h0);
        xact(1'b1, 1'b0, 1'b1, 24'h00, 64'h1234, 1'b0, rd, rp, sb, lat);
        check("cfg_wr_ack", 64'(lat), 64'd2);
        check("cfg_wr_stb", 64'(sb), 64'h0);

        // read-only register 3
        xact(1'b0, 1'b0, 1'b1, 24'h06, 64'h1111, 1'b0, rd, rp, sb, lat);
        check("ro_lat", 64'(lat), 64'd2);
        check("ro_stb", 64'(sb), 64'h0);
        @(negedge clock);
        check("ro_reg3", reg_out[3*64 +: 64], 64'h0);
        xact(1'b0, 1'b1, 1'b1, 24'h06, 64'h0, 1'b0, rd, rp, sb, lat);
        check("ro_rd", rd, 64'hFECA000000000000);

        // out-of-range index 20
        xact(1'b0, 1'b1, 1'b1, 24'h28, 64'h0, 1'b0, rd, rp, sb, lat);
        check("oor_rd", rd, 64'h0);
        check("oor_lat", 64'(lat), 64'd2);
        xact(1'b0, 1'b0, 1'b1, 24'h28, 64'hFF, 1'b0, rd, rp, sb, lat);
        check("oor_stb", 64'(sb), 64'h0);
        check("proto_clean", 64'(protocol_error), 64'h0);

        // second valid while busy
        @(negedge clock);
        mmio_in.valid          = 1'b1;
        mmio_in.cfg            = 1'b0;
        mmio_in.read           = 1'b0;
        mmio_in.doubleword     = 1'b1;
        mmio_in.address        = 24'h08;
        mmio_in.address_parity = ~^24'h08;
        mmio_in.data           = 64'hA1;
        mmio_in.data_parity    = ~^64'hA1;
        @(negedge clock);
        mmio_in.address        = 24'h0A;
        mmio_in.address_parity = ~^24'h0A;
        mmio_in.data           = 64'hB2;
        mmio_in.data_parity    = ~^64'hB2;
        @(negedge clock);
        mmio_in.valid = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            if (mmio_out.ack) acks++;
            @(negedge clock);
        end
        check("busy_acks", 64'(acks), 64'd1);
        check("busy_proto", 64'(protocol_error), 64'h1);
        check("busy_reg4", reg_out[4*64 +: 64], 64'hA100000000000000);
        check("busy_reg5", reg_out[5*64 +: 64], 64'h0);

        // misaligned doubleword
        xact(1'b0, 1'b1, 1'b1, 24'h07, 64'h0, 1'b0, rd, rp, sb, lat);
        check("mis_rd", rd, 64'h0);
        check("mis_lat", 64'(lat), 64'd2);
        xact(1'b0, 1'b0, 1'b1, 24'h03, 64'h77, 1'b0, rd, rp, sb, lat);
        check("mis_wr_stb", 64'(sb), 64'h0);
        @(negedge clock);
        check("mis_reg1", reg_out[1*64 +: 64], 64'h0);

        // write with bad data parity
        xact(1'b0, 1'b0, 1'b1, 24'h0C, 64'h5555, 1'b1, rd, rp, sb, lat);
        check("par_lat", 64'(lat), 64'd2);
        @(negedge clock);
`ifdef MMIO_PARITY_CHECK_EN
        check("par_err", 64'(parity_error), 64'h1);
        check("par_reg6", reg_out[6*64 +: 64], 64'h0);
`else
        check("par_err", 64'(parity_error), 64'h0);
        check("par_reg6", reg_out[6*64 +: 64], 64'h5555000000000000);
`endif

        // reset during WAIT
        @(negedge clock);
        mmio_in.valid          = 1'b1;
        mmio_in.read           = 1'b1;
        mmio_in.doubleword     = 1'b1;
        mmio_in.address        = 24'h04;
        mmio_in.address_parity = ~^24'h04;
        @(negedge clock);
        mmio_in.valid = 1'b0;
        reset         = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            if (mmio_out.ack) acks++;
            @(negedge clock);
        end
        check("rstw_acks", 64'(acks), 64'd0);
        check("rstw_data", mmio_out.data, 64'h0);
        check("rstw_reg2", reg_out[2*64 +: 64], 64'h0);
        check("rstw_reg4", reg_out[4*64 +: 64], 64'h0);
        check("rstw_proto", 64'(protocol_error), 64'h0);
        check("rstw_perr", 64'(parity_error), 64'h0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("post_rst_ack", 64'(mmio_out.ack), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
